wb_mem_arbiter: RTL and testbench
=================================

# wb_mem_arbiter

Two-master Wishbone (classic, B4) arbiter that shares one memory slave port between the core instruction-fetch master (m0) and the core data master (m1). It sits between `processor_core` and a single shared memory in the `rv32i_soc` fabric. It provides:
- round-robin grant on contention;
- bus hold for the full `cyc` duration;
- a watchdog that terminates stalled cycles with an error.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; `sel` width is `DATA_W/8`.
- `TIMEOUT`, 255: stalled-strobe cycles before forced error (1..65535); counter width is `$clog2(TIMEOUT+1)`.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `i_m0_cyc`, `i_m0_stb`, `i_m0_we` in 1 each: master 0 (ifetch) control.
- `i_m0_adr` in ADDR_W, `i_m0_dat` in DATA_W, `i_m0_sel` in DATA_W/8: master 0 request.
- `o_m0_dat` out DATA_W, `o_m0_ack` out 1, `o_m0_err` out 1: master 0 response.
- `i_m1_*` / `o_m1_*`: identical set for master 1 (data port).
- `o_s_cyc`, `o_s_stb`, `o_s_we` out 1; `o_s_adr` out ADDR_W; `o_s_dat` out DATA_W; `o_s_sel` out DATA_W/8: to the slave.
- `i_s_dat` in DATA_W, `i_s_ack` in 1, `i_s_err` in 1: from the slave.
- `o_grant` out 2: one-hot current owner; 2'b00 when idle.

## Operation
- **States:** IDLE, GNT0, GNT1, held in a state register. A `last` register records the most recent owner.
- **Request:** master `x` requests when `i_mx_cyc & i_mx_stb`.
- **IDLE:**
  - Only m0 requests → GNT0.
  - Only m1 requests → GNT1.
  - Both request → grant the master that is not `last`.
  - No request → stay in IDLE.
  - On entering GNTx, `last` ← x.
- **GNTx:**
  - Stay while `i_mx_cyc` = 1, so block cycles keep the bus.
  - When `i_mx_cyc` = 0, go to IDLE. The requester is not considered in that same cycle.
- **Mux (combinational from state):**
  - In GNTx, `o_s_cyc/stb/we/adr/dat/sel` = master x inputs.
  - In IDLE, all `o_s_*` = 0.
  - `o_mx_ack = i_s_ack` and `o_mx_err = i_s_err | wd_err`, only while in GNTx; the non-owner sees 0.
  - `o_m0_dat` and `o_m1_dat` are both driven by `i_s_dat` at all times; masters qualify it with ack.
- **Watchdog:**
  - Counter `wd` increments each cycle with `o_s_cyc & o_s_stb & ~i_s_ack & ~i_s_err`.
  - `wd` clears on ack, err, stb low, or leaving GNTx.
  - When `wd == TIMEOUT-1` and the stall condition holds, `wd_err` = 1 for that one cycle and `wd` clears.
  - The owner must then drop `cyc`. If it keeps strobing, the watchdog rearms.
- **Reset:** state ← IDLE, `last` ← 1 (m0 wins the first tie), `wd` ← 0. Every output is 0 during and immediately after reset, except `o_mx_dat`, which follows `i_s_dat`.

## Timing
- **Arbitration latency:** request first seen in IDLE at edge N → `o_grant` and `o_s_cyc` asserted from edge N+1.
- **Response path:** `i_s_ack`/`i_s_err` reach the owner in the same cycle; no added latency or registering.
- **Release:** owner drops `cyc` in cycle R → IDLE after edge R+1. A pending other master is granted after edge R+2, so there is exactly one idle bus cycle between owners.
- **Contention:** a master holding `cyc` continuously is never preempted. Fairness applies only at IDLE decisions.
- **Simultaneous release and request:** handled by the IDLE pass above; no request is lost while it is held.
- **Reset mid-cycle:** `reset` at edge N forces IDLE after edge N. `o_s_cyc` = 0 and any in-flight ack is not forwarded from N onward.
- **Slave error vs. timeout:** a slave `err` and the timeout in the same cycle produce a single err pulse.

## Test plan
1. **Single master:** m1 read, adr 0x0000_0010, slave acks 2 cycles after stb with 0xDEADBEEF.
   - `o_grant` = 2'b10 one cycle after request.
   - `o_m1_ack` pulses with `o_m1_dat` = 0xDEADBEEF.
   - `o_m0_ack` stays 0.
2. **Tie after reset:** m0 and m1 request in the same cycle.
   - GNT0 first; after m0 drops `cyc`, one idle cycle, then GNT1.
   - Repeat the tie → order alternates (m0 then m1, since `last` = 1 after the second grant).
3. **Block cycle:** m0 holds `cyc` for 4 acked beats while m1 requests.
   - m1 is not granted until 2 cycles after m0 drops `cyc`.
   - All 4 `o_m0_ack` pulses arrive.
4. **Watchdog:** TIMEOUT=8, slave never acks a m1 write.
   - `o_m1_err` pulses exactly 8 cycles after stb assertion in GNT1.
   - `o_m0_err` = 0; `wd` clears afterward.
5. **Reset mid-transaction:** assert `reset` while GNT1 with stb high.
   - Next cycle `o_s_cyc` = 0 and `o_grant` = 0.
   - After release, a simultaneous request grants m0.
6. **Slave error passthrough:** slave returns `i_s_err` to m0.
   - `o_m0_err` = 1 in the same cycle, `o_m0_ack` = 0, and state remains GNT0 until m0 drops `cyc`.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - two-master Wishbone B4 arbiter with round-robin, cyc hold and stall watchdog
module wb_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_m0_cyc,
   input  logic                i_m0_stb,
   input  logic                i_m0_we,
   input  logic [ADDR_W-1:0]   i_m0_adr,
   input  logic [DATA_W-1:0]   i_m0_dat,
   input  logic [DATA_W/8-1:0] i_m0_sel,
   output logic [DATA_W-1:0]   o_m0_dat,
   output logic                o_m0_ack,
   output logic                o_m0_err,
   input  logic                i_m1_cyc,
   input  logic                i_m1_stb,
   input  logic                i_m1_we,
   input  logic [ADDR_W-1:0]   i_m1_adr,
   input  logic [DATA_W-1:0]   i_m1_dat,
   input  logic [DATA_W/8-1:0] i_m1_sel,
   output logic [DATA_W-1:0]   o_m1_dat,
   output logic                o_m1_ack,
   output logic                o_m1_err,
   output logic                o_s_cyc,
   output logic                o_s_stb,
   output logic                o_s_we,
   output logic [ADDR_W-1:0]   o_s_adr,
   output logic [DATA_W-1:0]   o_s_dat,
   output logic [DATA_W/8-1:0] o_s_sel,
   input  logic [DATA_W-1:0]   i_s_dat,
   input  logic                i_s_ack,
   input  logic                i_s_err,
   output logic [1:0]          o_grant
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_last;
   logic [WD_W-1:0] r_wd;

   logic w_req0, w_req1, w_own0, w_own1, w_stall, w_wd_err;

   assign w_req0 = i_m0_cyc & i_m0_stb;
   assign w_req1 = i_m1_cyc & i_m1_stb;
   // Ownership is masked by reset so nothing reaches the slave or masters while it is held
   assign w_own0 = (r_state == GNT0) & ~reset;
   assign w_own1 = (r_state == GNT1) & ~reset;
   assign w_stall = ((w_own0 & i_m0_cyc & i_m0_stb) | (w_own1 & i_m1_cyc & i_m1_stb))
                    & ~i_s_ack & ~i_s_err;
   assign w_wd_err = w_stall & (r_wd == WD_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_wd    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_next == GNT0) r_last <= 1'b0;
         if (r_state == IDLE && w_next == GNT1) r_last <= 1'b1;
         r_wd <= (w_stall & ~w_wd_err) ? r_wd + WD_W'(1) : '0;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_req0 & w_req1) w_next = r_last ? GNT0 : GNT1;
            else if (w_req0)     w_next = GNT0;
            else if (w_req1)     w_next = GNT1;
         end
         GNT0:    if (!i_m0_cyc) w_next = IDLE;
         GNT1:    if (!i_m1_cyc) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_s_cyc  = 1'b0;
      o_s_stb  = 1'b0;
      o_s_we   = 1'b0;
      o_s_adr  = '0;
      o_s_dat  = '0;
      o_s_sel  = '0;
      o_m0_ack = 1'b0;
      o_m0_err = 1'b0;
      o_m1_ack = 1'b0;
      o_m1_err = 1'b0;
      o_grant  = 2'b00;
      o_m0_dat = i_s_dat;
      o_m1_dat = i_s_dat;
      if (w_own0) begin
         o_s_cyc  = i_m0_cyc;
         o_s_stb  = i_m0_stb;
         o_s_we   = i_m0_we;
         o_s_adr  = i_m0_adr;
         o_s_dat  = i_m0_dat;
         o_s_sel  = i_m0_sel;
         o_m0_ack = i_s_ack;
         o_m0_err = i_s_err | w_wd_err;
         o_grant  = 2'b01;
      end else if (w_own1) begin
         o_s_cyc  = i_m1_cyc;
         o_s_stb  = i_m1_stb;
         o_s_we   = i_m1_we;
         o_s_adr  = i_m1_adr;
         o_s_dat  = i_m1_dat;
         o_s_sel  = i_m1_sel;
         o_m1_ack = i_s_ack;
         o_m1_err = i_s_err | w_wd_err;
         o_grant  = 2'b10;
      end
   end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb/tb_wb_mem_arbiter.sv - randomized bench for wb_mem_arbiter against a transaction-level model
module tb_wb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic reset;
   logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [AW-1:0] m0_adr, m1_adr;
   logic [DW-1:0] m0_dat, m1_dat;
   logic [3:0]    m0_sel, m1_sel;
   logic [DW-1:0] o_m0_dat, o_m1_dat;
   logic o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
   logic o_s_cyc, o_s_stb, o_s_we;
   logic [AW-1:0] o_s_adr;
   logic [DW-1:0] o_s_dat;
   logic [3:0]    o_s_sel;
   logic [DW-1:0] s_dat;
   logic s_ack, s_err;
   logic [1:0] o_grant;

   int n_checks = 0;
   int n_errors = 0;
   int own  = -1;
   int last = 1;
   int run  = 0;
   bit stall_now;
   int m1_err_pulses;

   always #5 clk = ~clk;

   wb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_adr(m0_adr),
      .i_m0_dat(m0_dat), .i_m0_sel(m0_sel),
      .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
      .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_adr(m1_adr),
      .i_m1_dat(m1_dat), .i_m1_sel(m1_sel),
      .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
      .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_adr(o_s_adr),
      .o_s_dat(o_s_dat), .o_s_sel(o_s_sel),
      .i_s_dat(s_dat), .i_s_ack(s_ack), .i_s_err(s_err),
      .o_grant(o_grant)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // Expected outputs for the current cycle, from the model owner and the live inputs
   task automatic check_all();
      logic [1:0]    e_grant;
      logic [6:0]    e_ctl;
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_dat;
      logic [1:0]    e_r0, e_r1;
      bit wd;
      e_grant = 2'b00; e_ctl = '0; e_adr = '0; e_dat = '0; e_r0 = '0; e_r1 = '0;
      stall_now = 1'b0;
      if (!reset && own == 0) begin
         e_grant = 2'b01;
         e_ctl = {m0_cyc, m0_stb, m0_we, m0_sel};
         e_adr = m0_adr; e_dat = m0_dat;
         stall_now = m0_cyc && m0_stb && !s_ack && !s_err;
      end else if (!reset && own == 1) begin
         e_grant = 2'b10;
         e_ctl = {m1_cyc, m1_stb, m1_we, m1_sel};
         e_adr = m1_adr; e_dat = m1_dat;
         stall_now = m1_cyc && m1_stb && !s_ack && !s_err;
      end
      // Every TO-th consecutive stalled cycle is terminated with an error
      wd = stall_now && ((run + 1) % TO == 0);
      if (!reset && own == 0) e_r0 = {s_ack, s_err | wd};
      if (!reset && own == 1) e_r1 = {s_ack, s_err | wd};
      check("grant", 64'(o_grant), 64'(e_grant));
      check("s_ctl", 64'({o_s_cyc, o_s_stb, o_s_we, o_s_sel}), 64'(e_ctl));
      check("s_adr", 64'(o_s_adr), 64'(e_adr));
      check("s_dat", 64'(o_s_dat), 64'(e_dat));
      check("m0_resp", 64'({o_m0_ack, o_m0_err}), 64'(e_r0));
      check("m1_resp", 64'({o_m1_ack, o_m1_err}), 64'(e_r1));
      check("m_dat", {o_m0_dat, o_m1_dat}, {s_dat, s_dat});
      m1_err_pulses += int'(o_m1_err);
   endtask

   task automatic model_edge();
      bit r0, r1;
      r0 = m0_cyc && m0_stb;
      r1 = m1_cyc && m1_stb;
      if (reset) begin
         own = -1; last = 1; run = 0;
      end else begin
         run = stall_now ? run + 1 : 0;
         if (own < 0) begin
            if (r0 && r1)  own = 1 - last;
            else if (r0)   own = 0;
            else if (r1)   own = 1;
            if (own >= 0)  last = own;
         end else if ((own == 0 && !m0_cyc) || (own == 1 && !m1_cyc)) begin
            own = -1;
         end
      end
   endtask

   task automatic cycle();
      #1;
      check_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_all();
      {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack, s_err} = '0;
   endtask

   initial begin
      reset = 1'b1;
      idle_all();
      m0_adr = 32'h100; m0_dat = 32'h1111_0000; m0_sel = 4'hF;
      m1_adr = 32'h200; m1_dat = 32'h2222_0000; m1_sel = 4'hF;
      s_dat = 32'h5A5A_A5A5;
      cycle(); cycle();
      reset = 1'b0;
      cycle();

      // single m1 read, ack two cycles after grant
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0010;
      cycle(); cycle(); cycle();
      s_ack = 1; s_dat = 32'hDEAD_BEEF;
      cycle();
      idle_all();
      cycle();

      // ties alternate, m0 first since last starts at m1
      repeat (2) begin
         m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
         cycle();
         s_ack = 1; cycle(); s_ack = 0;
         m0_cyc = 0; m0_stb = 0; cycle();
         cycle();
         s_ack = 1; cycle(); s_ack = 0;
         m1_cyc = 0; m1_stb = 0; cycle();
      end

      // m0 block of four beats while m1 waits
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      cycle();
      for (int b = 0; b < 4; b++) begin
         s_ack = 1; cycle(); s_ack = 0; cycle();
      end
      m0_cyc = 0; m0_stb = 0; cycle(); cycle(); cycle();
      idle_all(); cycle();

      // stalled m1 write: one watchdog error in ten stalled cycles
      m1_cyc = 1; m1_stb = 1; m1_we = 1;
      cycle();
      m1_err_pulses = 0;
      repeat (10) cycle();
      check("wd_pulses", 64'(m1_err_pulses), 64'd1);
      idle_all(); cycle();

      // reset mid-transaction, then a tie must go to m0
      m1_cyc = 1; m1_stb = 1; cycle(); cycle();
      reset = 1; cycle();
      reset = 0; idle_all();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      cycle(); cycle();
      check("tie_after_reset", 64'(o_grant), 64'(2'b01));
      s_err = 1; cycle(); s_err = 0; cycle();
      idle_all(); cycle(); cycle();

      for (int i = 0; i < 3000; i++) begin
         bit stall_phase;
         stall_phase = ((i / 250) % 2) == 1;
         reset = ($urandom_range(0, 299) == 0);
         if (m0_cyc) m0_cyc = ($urandom_range(0, stall_phase ? 15 : 4) != 0);
         else        m0_cyc = ($urandom_range(0, 2) == 0);
         if (m1_cyc) m1_cyc = ($urandom_range(0, stall_phase ? 15 : 4) != 0);
         else        m1_cyc = ($urandom_range(0, 2) == 0);
         m0_stb = m0_cyc && (stall_phase || $urandom_range(0, 3) != 0);
         m1_stb = m1_cyc && (stall_phase || $urandom_range(0, 3) != 0);
         m0_we = 1'($urandom); m1_we = 1'($urandom);
         m0_adr = $urandom; m1_adr = $urandom;
         m0_dat = $urandom; m1_dat = $urandom;
         m0_sel = 4'($urandom); m1_sel = 4'($urandom);
         s_dat = $urandom;
         s_ack = !stall_phase && ($urandom_range(0, 2) == 0);
         s_err = ($urandom_range(0, stall_phase ? 60 : 19) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
